// File: rtl/noc_pkg.sv
// Shared NoC definitions for the router datapath.
// Contents:
//   P_NORTH..P_LOCAL  port index constants (extra ports follow P_LOCAL)
//   NPORTS_DEFAULT    default router port count
//   FLIT_W_DEFAULT    default flit width in bits
//   flit_t            flit word at the default width
package noc_pkg;

  localparam int P_NORTH = 0;
  localparam int P_EAST  = 1;
  localparam int P_SOUTH = 2;
  localparam int P_WEST  = 3;
  localparam int P_LOCAL = 4;

  localparam int NPORTS_DEFAULT = 5;
  localparam int FLIT_W_DEFAULT = 64;

  typedef logic [FLIT_W_DEFAULT-1:0] flit_t;

endpackage

// File: rtl/xbar_credit_cnt.sv
// Per-output credit counter for the switch-traversal crossbar.
// Tracks the free slots in the downstream input buffer.
// Ports:
//   clk, rst   clock and asynchronous active-high reset (reset value CREDITS)
//   send       a flit leaves through this output this cycle (consumes a slot)
//   credit_in  downstream returned one slot this cycle
//   cnt        registered credit count
//   avail      cnt != 0
//   overflow   credit returned while already full and not sending
module xbar_credit_cnt
  import noc_pkg::*;
#(
  parameter  int CREDITS = 4,
  localparam int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send,
  input  logic             credit_in,
  output logic [CNT_W-1:0] cnt,
  output logic             avail,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic full;
  logic empty;

  assign full     = (cnt == CNT_MAX);
  assign empty    = (cnt == '0);
  assign avail    = !empty;
  // A send and a return in the same cycle cancel out, so only a lone
  // return against a full counter is an overflow.
  assign overflow = credit_in && !send && full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= CNT_MAX;
    end else begin
      case ({send, credit_in})
        2'b10: if (!empty) cnt <= cnt - CNT_ONE;
        2'b01: if (!full)  cnt <= cnt + CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/xbar_switch_traversal.sv
// Registered NPORTS x NPORTS switch-traversal crossbar.
// Every output independently selects one input (one-hot) and forwards its
// flit through one output register when the input is valid and the output
// holds a downstream credit.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   flit_in       NPORTS input flits, slice i = input i
//   valid_in      per-input flit valid
//   out_sel       per-output one-hot input select, slice o bit i = o takes i
//   credit_in     per-output credit return pulse from downstream
//   flit_out      registered output flits (zero when idle)
//   valid_out     registered output valid
//   ack_in        combinational: input i's flit is consumed this cycle
//   credit_avail  per-output credit counter != 0
//   sel_err       registered pulse on illegal select or credit overflow
module xbar_switch_traversal
  import noc_pkg::*;
#(
  parameter int NPORTS  = NPORTS_DEFAULT,
  parameter int FLIT_W  = FLIT_W_DEFAULT,
  parameter int CREDITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS*FLIT_W-1:0] flit_in,
  input  logic [NPORTS-1:0]        valid_in,
  input  logic [NPORTS*NPORTS-1:0] out_sel,
  input  logic [NPORTS-1:0]        credit_in,
  output logic [NPORTS*FLIT_W-1:0] flit_out,
  output logic [NPORTS-1:0]        valid_out,
  output logic [NPORTS-1:0]        ack_in,
  output logic [NPORTS-1:0]        credit_avail,
  output logic                     sel_err
);

  localparam int CNT_W = $clog2(CREDITS + 1);

  logic [NPORTS-1:0] legal_sel [NPORTS];
  logic [NPORTS-1:0] sel_bad;
  logic [NPORTS-1:0] send;
  logic [NPORTS-1:0] ack;
  logic [NPORTS-1:0] overflow;
  logic [CNT_W-1:0]  cnt [NPORTS];
  logic [FLIT_W-1:0] flit_nxt [NPORTS];
  logic              sel_err_nxt;

  logic [FLIT_W-1:0] flit_p1 [NPORTS];
  logic [NPORTS-1:0] vld_p1;
  logic              sel_err_p1;

  // ---- stage p0: select legalisation, transfer decision, mux ----

  // Outputs are scanned in index order so an input claimed by a lower
  // output is unavailable to higher ones. Only a legal one-hot select
  // claims its input; malformed selects are dropped without claiming.
  always_comb begin
    logic [NPORTS-1:0] claimed;
    logic [NPORTS-1:0] sel_raw;
    claimed = '0;
    sel_bad = '0;
    for (int o = 0; o < NPORTS; o++) begin
      sel_raw      = out_sel[o*NPORTS +: NPORTS];
      legal_sel[o] = '0;
      if (sel_raw == '0) begin
        legal_sel[o] = '0;
      end else if (!$onehot(sel_raw) || ((sel_raw & claimed) != '0)) begin
        sel_bad[o] = 1'b1;
      end else begin
        legal_sel[o] = sel_raw;
        claimed      = claimed | sel_raw;
      end
    end
  end

  // Eligibility uses the registered count, so a credit returned this
  // cycle only enables a transfer on the following cycle.
  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      send[o] = ((legal_sel[o] & valid_in) != '0) && (cnt[o] != '0);
    end
  end

  always_comb begin
    ack = '0;
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (send[o] && legal_sel[o][i]) ack[i] = 1'b1;
      end
    end
  end

  assign ack_in = rst ? '0 : ack;

  // Idle outputs load zero rather than holding their last flit.
  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      flit_nxt[o] = '0;
      if (send[o]) begin
        for (int i = 0; i < NPORTS; i++) begin
          if (legal_sel[o][i]) flit_nxt[o] = flit_in[i*FLIT_W +: FLIT_W];
        end
      end
    end
  end

  assign sel_err_nxt = (sel_bad != '0) || (overflow != '0);

  for (genvar o = 0; o < NPORTS; o++) begin : g_cnt
    xbar_credit_cnt #(
      .CREDITS (CREDITS)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .send      (send[o]),
      .credit_in (credit_in[o]),
      .cnt       (cnt[o]),
      .avail     (credit_avail[o]),
      .overflow  (overflow[o])
    );
  end

  // ---- stage p1: output registers ----

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < NPORTS; o++) flit_p1[o] <= '0;
      vld_p1     <= '0;
      sel_err_p1 <= 1'b0;
    end else begin
      for (int o = 0; o < NPORTS; o++) flit_p1[o] <= flit_nxt[o];
      vld_p1     <= send;
      sel_err_p1 <= sel_err_nxt;
    end
  end

  always_comb begin
    for (int o = 0; o < NPORTS; o++) flit_out[o*FLIT_W +: FLIT_W] = flit_p1[o];
  end

  assign valid_out = vld_p1;
  assign sel_err   = sel_err_p1;

endmodule
